// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS MEM-stage data-memory responder: access sizes,
// read/write direction, responder FSM states and the load extension helper.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } mem_state_e;

    // Sign- or zero-extend a byte (v[7:0]) or halfword (v[15:0]) to 32 bits.
    function automatic logic [31:0] extend_lane(input logic [15:0] v,
                                                input logic        is_half,
                                                input logic        signe);
        logic [31:0] res;
        if (is_half) begin
            res = signe ? {{16{v[15]}}, v} : {16'h0000, v};
        end else begin
            res = signe ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// EX/MEM load/store request bus between the pipeline (master) and the
// data-memory responder (slave).
interface mips_data_mem_responder_if;

    logic        MEM_ENABLE;
    logic        MEM_READWRITE;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGNE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_BUSY;
    logic        MEM_DONE;
    logic        MEM_ERR;

    modport master (
        output MEM_ENABLE, MEM_READWRITE, MEM_SIZE, MEM_SIGNE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA, MEM_BUSY, MEM_DONE, MEM_ERR
    );

    modport slave (
        input  MEM_ENABLE, MEM_READWRITE, MEM_SIZE, MEM_SIGNE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA, MEM_BUSY, MEM_DONE, MEM_ERR
    );

endinterface

// File: rtl/mips_mem_lane_align.sv
// Big-endian lane steering: store byte enables / replicated write data, and
// load lane selection with sign or zero extension. Size 11 behaves as word.
module mips_mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signe,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'b00:   w_byte = i_rword[31:24];
            2'b01:   w_byte = i_rword[23:16];
            2'b10:   w_byte = i_rword[15:8];
            2'b11:   w_byte = i_rword[7:0];
            default: w_byte = 8'h00;
        endcase
        if (i_offset[1]) begin
            w_half = i_rword[15:0];
        end else begin
            w_half = i_rword[31:16];
        end
    end

    // Lane enables, write-data replication and load extension per access size.
    always_comb begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        o_rdata = i_rword;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b1000 >> i_offset;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = extend_lane({8'h00, w_byte}, 1'b0, i_signe);
            end
            SIZE_HALF: begin
                o_be    = i_offset[1] ? 4'b0011 : 4'b1100;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = extend_lane(w_half, 1'b1, i_signe);
            end
            default: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/mips_data_mem_responder.sv
// MEM-stage data-memory responder: multi-cycle big-endian byte/half/word access
// with stall request. Define MIPS_MEM_ALIGN_CHECK_EN to enable MEM_ERR checking.
module mips_data_mem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS * 4),
    parameter int LATENCY     = 2
)
(
    input  logic                       Clk,
    input  logic                       Reset,
    mips_data_mem_responder_if.slave   mem
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e         r_state;
    mem_state_e         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_rw;
    logic [1:0]         r_size;
    logic               r_signe;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_done;
    logic               r_err;
    logic               r_recover;
    logic               r_run;

    logic               w_accept;
    logic               w_busy;
    logic               w_commit;
    logic               w_err;
    logic               w_we;
    logic               w_src_rw;
    logic [1:0]         w_src_size;
    logic               w_src_signe;
    logic [31:0]        w_src_addr;
    logic [31:0]        w_src_wdata;
    logic [ADDR_W-3:0]  w_idx;
    logic [31:0]        w_rword;
    logic [3:0]         w_be;
    logic [31:0]        w_wword;
    logic [31:0]        w_load;

    logic [31:0]        r_mem [DEPTH_WORDS];

    // With LATENCY=1 the commit edge is also the acceptance edge, so the live
    // inputs feed the datapath while IDLE and the captured request otherwise.
    assign w_src_rw    = (r_state == IDLE) ? mem.MEM_READWRITE : r_rw;
    assign w_src_size  = (r_state == IDLE) ? mem.MEM_SIZE      : r_size;
    assign w_src_signe = (r_state == IDLE) ? mem.MEM_SIGNE     : r_signe;
    assign w_src_addr  = (r_state == IDLE) ? mem.MEM_ADDR      : r_addr;
    assign w_src_wdata = (r_state == IDLE) ? mem.MEM_WDATA     : r_wdata;

    // r_recover holds off acceptance for one IDLE cycle after DONE so the
    // pipeline can advance EX/MEM; r_run blanks everything while in reset.
    assign w_accept = (r_state == IDLE) & mem.MEM_ENABLE & ~r_recover & r_run;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign w_err = (w_src_size == SIZE_ILL)
                 | ((w_src_size == SIZE_HALF) & w_src_addr[0])
                 | ((w_src_size == SIZE_WORD) & (w_src_addr[1:0] != 2'b00))
                 | (w_src_addr >= 32'(DEPTH_WORDS * 4));
`else
    logic w_unused_addr;
    assign w_err         = 1'b0;
    assign w_unused_addr = ^w_src_addr[31:ADDR_W];
`endif

    assign w_idx   = w_src_addr[ADDR_W-1:2];
    assign w_rword = r_mem[w_idx];
    assign w_we    = w_commit & (w_src_rw == MEM_WRITE) & ~w_err;

    mips_mem_lane_align u_lane (
        .i_size   (w_src_size),
        .i_signe  (w_src_signe),
        .i_offset (w_src_addr[1:0]),
        .i_wdata  (w_src_wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wword  (w_wword),
        .o_rdata  (w_load)
    );

    // Next-state, latency counter, stall request and commit strobe.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_busy     = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_busy     = 1'b1;
                    w_cnt_next = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        w_next = ACCESS;
                    end else begin
                        w_next   = DONE;
                        w_commit = 1'b1;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next   = DONE;
                    w_commit = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // FSM state, request capture and registered response.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_rw      <= 1'b0;
            r_size    <= 2'b00;
            r_signe   <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
            r_rdata   <= 32'h0000_0000;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_recover <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_commit;
            r_err     <= w_commit & w_err;
            r_recover <= (r_state == DONE);
            r_run     <= 1'b1;
            if (w_accept) begin
                r_rw    <= mem.MEM_READWRITE;
                r_size  <= mem.MEM_SIZE;
                r_signe <= mem.MEM_SIGNE;
                r_addr  <= mem.MEM_ADDR;
                r_wdata <= mem.MEM_WDATA;
            end
            if (w_commit && (w_src_rw == MEM_READ)) begin
                r_rdata <= w_err ? 32'h0000_0000 : w_load;
            end
        end
    end

    // Byte-lane writes into the unreset storage array.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) begin
                r_mem[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
            end
        end
    end

    assign mem.MEM_BUSY  = w_busy;
    assign mem.MEM_DONE  = r_done;
    assign mem.MEM_ERR   = r_err;
    assign mem.MEM_RDATA = r_rdata;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Self-checking bench for mips_data_mem_responder: table-driven accesses plus
// back-to-back and reset-mid-store sequences.
`timescale 1ns/1ps
module tb_mips_data_mem_responder;
    import mips_pkg::*;

    localparam int LATENCY = 2;
    localparam int TIMEOUT = 4 * LATENCY + 10;

    typedef struct {
        string       name;
        logic        rw;
        logic [1:0]  size;
        logic        signe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    mips_data_mem_responder_if bus ();

    mips_data_mem_responder #(
        .DEPTH_WORDS (128),
        .ADDR_W      (9),
        .LATENCY     (LATENCY)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic rw, input logic [1:0] size,
                           input logic signe, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.rw = rw; v.size = size; v.signe = signe;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // One request; request fields are scrambled after acceptance to prove they are ignored.
    task automatic do_access(input logic rw, input logic [1:0] size, input logic signe,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int busy_n, output int done_at);
        bit got;
        busy_n = 0; done_at = -1; rdata = 32'h0; err = 1'b0; got = 1'b0;
        @(negedge clk);
        bus.MEM_ENABLE = 1'b1; bus.MEM_READWRITE = rw; bus.MEM_SIZE = size;
        bus.MEM_SIGNE = signe; bus.MEM_ADDR = addr; bus.MEM_WDATA = wdata;
        for (int cyc = 0; cyc < TIMEOUT && !got; cyc++) begin
            if (cyc == 1) begin
                bus.MEM_ADDR  = ~addr;
                bus.MEM_WDATA = ~wdata;
            end
            #1;
            if (bus.MEM_BUSY) busy_n++;
            if (bus.MEM_DONE) begin
                got = 1'b1; done_at = cyc;
                rdata = bus.MEM_RDATA; err = bus.MEM_ERR;
                bus.MEM_ENABLE = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.MEM_ENABLE = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          bn, da, first, second, nb, nd;
        logic [31:0] exp_w10;

        bus.MEM_ENABLE = 1'b0; bus.MEM_READWRITE = MEM_READ; bus.MEM_SIZE = SIZE_WORD;
        bus.MEM_SIGNE = 1'b0; bus.MEM_ADDR = 32'h0; bus.MEM_WDATA = 32'h0;

        add_vec("st_w10",    MEM_WRITE, SIZE_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
        add_vec("ld_w10",    MEM_READ,  SIZE_WORD, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        add_vec("ld_b11_s",  MEM_READ,  SIZE_BYTE, 1'b1, 32'h011, 32'h0,        32'hFFFFFFAD, 1'b0);
        add_vec("ld_b11_z",  MEM_READ,  SIZE_BYTE, 1'b0, 32'h011, 32'h0,        32'h000000AD, 1'b0);
        add_vec("st_h12",    MEM_WRITE, SIZE_HALF, 1'b0, 32'h012, 32'h00001234, 32'h000000AD, 1'b0);
        add_vec("ld_w10_b",  MEM_READ,  SIZE_WORD, 1'b0, 32'h010, 32'h0,        32'hDEAD1234, 1'b0);
        add_vec("ld_h10_s",  MEM_READ,  SIZE_HALF, 1'b1, 32'h010, 32'h0,        32'hFFFFDEAD, 1'b0);
        add_vec("st_b13",    MEM_WRITE, SIZE_BYTE, 1'b0, 32'h013, 32'h00000080, 32'hFFFFDEAD, 1'b0);
        add_vec("ld_b13_s",  MEM_READ,  SIZE_BYTE, 1'b1, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0);
        add_vec("ld_h12_z",  MEM_READ,  SIZE_HALF, 1'b0, 32'h012, 32'h0,        32'h00001280, 1'b0);
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        add_vec("err_ld_w13",  MEM_READ,  SIZE_WORD, 1'b0, 32'h013, 32'h0,        32'h00000000, 1'b1);
        add_vec("err_st_h201", MEM_WRITE, SIZE_HALF, 1'b0, 32'h201, 32'h0000BEEF, 32'h00000000, 1'b1);
        add_vec("err_st_h212", MEM_WRITE, SIZE_HALF, 1'b0, 32'h212, 32'h0000BEEF, 32'h00000000, 1'b1);
        add_vec("err_st_w11",  MEM_WRITE, SIZE_WORD, 1'b0, 32'h011, 32'hCAFEBABE, 32'h00000000, 1'b1);
        add_vec("err_ld_sz3",  MEM_READ,  SIZE_ILL,  1'b0, 32'h010, 32'h0,        32'h00000000, 1'b1);
        add_vec("err_ld_w200", MEM_READ,  SIZE_WORD, 1'b0, 32'h200, 32'h0,        32'h00000000, 1'b1);
        add_vec("ld_w10_kept", MEM_READ,  SIZE_WORD, 1'b0, 32'h010, 32'h0,        32'hDEAD1280, 1'b0);
        exp_w10 = 32'hDEAD1280;
`else
        add_vec("ld_w13_ign",  MEM_READ,  SIZE_WORD, 1'b0, 32'h013, 32'h0,        32'hDEAD1280, 1'b0);
        add_vec("ld_w210_wrap",MEM_READ,  SIZE_WORD, 1'b0, 32'h210, 32'h0,        32'hDEAD1280, 1'b0);
        add_vec("st_h213_wrap",MEM_WRITE, SIZE_HALF, 1'b0, 32'h213, 32'h0000BEEF, 32'hDEAD1280, 1'b0);
        add_vec("ld_sz3_word", MEM_READ,  SIZE_ILL,  1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        add_vec("ld_h211_z",   MEM_READ,  SIZE_HALF, 1'b0, 32'h211, 32'h0,        32'h0000DEAD, 1'b0);
        exp_w10 = 32'hDEADBEEF;
`endif

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("reset busy",  32'(bus.MEM_BUSY), 32'h0);
        check("reset done",  32'(bus.MEM_DONE), 32'h0);
        check("reset err",   32'(bus.MEM_ERR),  32'h0);
        check("reset rdata", bus.MEM_RDATA,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_access(vecs[i].rw, vecs[i].size, vecs[i].signe, vecs[i].addr, vecs[i].wdata,
                      rd, er, bn, da);
            check({vecs[i].name, " busy_cycles"}, bn, LATENCY);
            check({vecs[i].name, " done_cycle"},  da, LATENCY);
            check({vecs[i].name, " rdata"},       rd, vecs[i].exp_rdata);
            check({vecs[i].name, " err"},         32'(er), 32'(vecs[i].exp_err));
        end

        // Back-to-back: enable held high across two loads
        @(negedge clk);
        bus.MEM_ENABLE = 1'b1; bus.MEM_READWRITE = MEM_READ; bus.MEM_SIZE = SIZE_WORD;
        bus.MEM_SIGNE = 1'b0; bus.MEM_ADDR = 32'h010;
        first = -1; second = -1; nb = 0; nd = 0;
        for (int c = 0; c < 2 * LATENCY + 4; c++) begin
            #1;
            if (bus.MEM_BUSY) nb++;
            if (bus.MEM_DONE) begin
                nd++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                check("b2b rdata", bus.MEM_RDATA, exp_w10);
            end
            @(negedge clk);
        end
        bus.MEM_ENABLE = 1'b0;
        check("b2b first_done",  first,  LATENCY);
        check("b2b second_done", second, 2 * LATENCY + 2);
        check("b2b busy_cycles", nb,     2 * LATENCY);
        check("b2b done_count",  nd,     2);
        @(negedge clk);

        // Reset in the middle of a store
        do_access(MEM_WRITE, SIZE_WORD, 1'b0, 32'h020, 32'h11223344, rd, er, bn, da);
        do_access(MEM_READ,  SIZE_WORD, 1'b0, 32'h020, 32'h0,        rd, er, bn, da);
        check("prior ld_w20", rd, 32'h11223344);
        @(negedge clk);
        bus.MEM_ENABLE = 1'b1; bus.MEM_READWRITE = MEM_WRITE; bus.MEM_SIZE = SIZE_WORD;
        bus.MEM_ADDR = 32'h020; bus.MEM_WDATA = 32'hCAFEF00D;
        #1;
        check("rst_mid busy_c0", 32'(bus.MEM_BUSY), 32'h1);
        @(negedge clk); #1;
        check("rst_mid busy_c1", 32'(bus.MEM_BUSY), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid busy",  32'(bus.MEM_BUSY), 32'h0);
        check("rst_mid done",  32'(bus.MEM_DONE), 32'h0);
        check("rst_mid err",   32'(bus.MEM_ERR),  32'h0);
        check("rst_mid rdata", bus.MEM_RDATA,     32'h0);
        bus.MEM_ENABLE = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        do_access(MEM_READ, SIZE_WORD, 1'b0, 32'h020, 32'h0, rd, er, bn, da);
        check("after_rst ld_w20",   rd, 32'h11223344);
        check("after_rst done_cyc", da, LATENCY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_data_mem_responder.md
# mips_data_mem_responder

Data-memory responder for the MEM stage of the five-stage MIPS pipeline. It accepts the load/store request the EX/MEM pipeline register presents (enable, read/write, size, sign-extend, address, store data), performs byte, halfword or word accesses on a big-endian word array over a configurable number of cycles, and returns load data. While an access is in progress it drives a stall request that the pipeline uses to hold its register enables low.

## Interface
- DEPTH_WORDS, 128: number of 32-bit words in the array (512 bytes).
- ADDR_W, 9: byte-address bits used, $clog2(DEPTH_WORDS*4).
- LATENCY, 2: access latency in cycles, must be ≥1.

- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- MEM_ENABLE  input  1  request valid from EX/MEM.
- MEM_READWRITE  input  1  0 = load (read), 1 = store (write).
- MEM_SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- MEM_SIGNE  input  1  1 = sign-extend a byte or halfword load, 0 = zero-extend.
- MEM_ADDR  input  32  byte address.
- MEM_WDATA  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- MEM_RDATA  output  32  load result, extended to 32 bits; reset 0.
- MEM_BUSY  output  1  stall request: the pipeline holds its LE low; reset 0.
- MEM_DONE  output  1  one-cycle completion pulse; reset 0.
- MEM_ERR  output  1  error flag, valid with MEM_DONE; reset 0.

## Operation
- FSM states are IDLE, ACCESS and DONE. Reset enters IDLE.
- **IDLE**
  - When MEM_ENABLE=1, capture READWRITE, SIZE, SIGNE, ADDR and WDATA into request registers and load the down-counter with LATENCY-1.
  - Go to ACCESS if LATENCY>1, otherwise go straight to DONE.
  - MEM_BUSY is asserted combinationally in this acceptance cycle, so the pipeline freezes immediately.
- **ACCESS**
  - MEM_BUSY=1. The counter decrements each cycle.
  - When the counter reaches 1, go to DONE on the next edge.
  - Inputs are ignored here; the captured request is authoritative.
- **Commit (transition into DONE)**
  - Store: write the selected byte lanes of word ADDR[ADDR_W-1:2].
    - Byte at offset k lands in bits [31-8k:24-8k].
    - Halfword at offset 0 lands in [31:16]; at offset 2 it lands in [15:0].
  - Load: read the word, select the lane, then sign- or zero-extend into MEM_RDATA.
- **DONE**
  - MEM_DONE=1 and MEM_BUSY=0 for exactly one cycle, then return to IDLE.
  - The still-high MEM_ENABLE of the completing request is ignored in DONE. The next request is accepted in IDLE one cycle later.
- **Errors**
  - An error is any of: SIZE=11, halfword with ADDR[0]=1, word with ADDR[1:0]≠00, or ADDR ≥ DEPTH_WORDS*4.
  - On error: no write, MEM_RDATA=0, MEM_ERR=1 in the DONE cycle.
- MEM_RDATA holds its value until the next completed load; stores do not alter it.
- The array itself is not reset. Its initial contents are undefined.

## Timing
- Acceptance happens at cycle 0 (the IDLE cycle with MEM_ENABLE=1).
- MEM_BUSY is high for cycles 0..LATENCY-1.
- MEM_DONE is high and MEM_RDATA is valid in cycle LATENCY.
- Throughput is one access per LATENCY+2 cycles.
- LATENCY=1: busy for one cycle, DONE in cycle 1.
- Reset asserted mid-access:
  - FSM goes to IDLE asynchronously and all outputs go to 0.
  - A store not yet committed is dropped; the array is unchanged.
- MEM_ENABLE deasserted during ACCESS does not abort the access.

## Configuration
- MIPS_MEM_ALIGN_CHECK_EN defined: alignment, size and range checking are performed as described above, and MEM_ERR is live.
- Not defined:
  - MEM_ERR is tied to 0.
  - Address bits below the access size are ignored: halfword uses ADDR[1] only, word ignores ADDR[1:0].
  - The address is truncated to ADDR_W bits and wraps.
  - SIZE=11 is treated as word.

## Structure
- Shared package mips_pkg holds:
  - MEM_SIZE encodings: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - READWRITE encodings: MEM_READ, MEM_WRITE.
  - The responder FSM state enum.
- One combinational sub-module, mips_mem_lane_align, performs store byte-enable and lane steering plus load lane selection and sign/zero extension.

## Test plan
- **Word round trip:** LATENCY=2; store word 0xDEADBEEF to 0x10, then load word from 0x10.
  - MEM_BUSY is high 2 cycles per access.
  - MEM_DONE pulses in cycle 2.
  - MEM_RDATA=0xDEADBEEF.
- **Byte loads:** after the store above, load byte at 0x11.
  - With MEM_SIGNE=1: MEM_RDATA=0xFFFFFFAD.
  - With MEM_SIGNE=0: MEM_RDATA=0x000000AD.
- **Halfword store:** store halfword 0x1234 to 0x12, then load word from 0x10 → MEM_RDATA=0xDEAD1234.
- **Error case (macro on):** load word from 0x13, then store halfword to 0x201.
  - Each access: MEM_ERR=1 with MEM_DONE and MEM_RDATA=0.
  - The array is unchanged.
- **Back-to-back requests:** hold MEM_ENABLE high across two consecutive requests.
  - The second request is accepted only in the IDLE cycle after DONE.
  - MEM_DONE pulses in cycle 2 and cycle 6.
- **Reset mid-store:** Reset low during ACCESS of a store of 0xCAFEF00D to 0x20.
  - All outputs go to 0 immediately.
  - A later load of 0x20 returns the prior contents.
